// File: rtl/accum_pkg.sv
// accum_pkg: opcode and sequencer state types shared by the accumulator bank
package accum_pkg;
  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_SHL  = 3'd6,
    OP_SHR  = 3'd7
  } op_t;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/accum_if.sv
// accum_if: request/response bus between a requester and the accumulator bank
interface accum_if import accum_pkg::*; #(parameter int BITS = 8, parameter int NACC = 4);
  localparam int SELW = $clog2(NACC);
  localparam int SHW = $clog2(BITS) + 1;
  logic i_valid;
  logic o_ready;
  op_t i_op;
  logic [SELW-1:0] i_sel;
  logic [BITS-1:0] i_data;
  logic [SHW-1:0] i_shamt;
  logic [BITS-1:0] o_data;
  logic o_zero;
  logic o_neg;
  logic o_carry;
  logic o_done;
  modport master (output i_valid, i_op, i_sel, i_data, i_shamt,
                  input o_ready, o_data, o_zero, o_neg, o_carry, o_done);
  modport slave (input i_valid, i_op, i_sel, i_data, i_shamt,
                 output o_ready, o_data, o_zero, o_neg, o_carry, o_done);
endinterface

// File: rtl/accum_alu.sv
// accum_alu: single-cycle result and carry for every opcode; shifts pass the operand through
module accum_alu import accum_pkg::*; #(parameter int BITS = 8) (
  input  op_t             op,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic [BITS-1:0] res,
  output logic            carry
);
  logic [BITS:0] sum, dif;
  assign sum = {1'b0, a} + {1'b0, b};
  // the extra top bit of the difference is the unsigned borrow
  assign dif = {1'b0, a} - {1'b0, b};
  assign res = op == OP_LOAD ? b :
               op == OP_ADD  ? sum[BITS-1:0] :
               op == OP_SUB  ? dif[BITS-1:0] :
               op == OP_AND  ? a & b :
               op == OP_OR   ? a | b :
               op == OP_XOR  ? a ^ b : a;
  assign carry = op == OP_ADD ? sum[BITS] : op == OP_SUB ? dif[BITS] : 1'b0;
endmodule

// File: rtl/accum_bank.sv
// accum_bank: bank of accumulators with single-cycle ALU ops and multi-cycle 1-bit-per-cycle shifts
module accum_bank import accum_pkg::*; #(parameter int BITS = 8, parameter int NACC = 4) (
  input logic i_clk,
  input logic i_rst_n,
  accum_if.slave bus
);
  localparam int SELW = $clog2(NACC);
  localparam int SHW = $clog2(BITS) + 1;
  logic [BITS-1:0] acc [NACC];
  state_t state;
  logic [SELW-1:0] tgt;
  logic [SHW-1:0] cnt;
  logic shl, carry, done;
  logic [BITS-1:0] rd, alu_res;
  logic alu_c, is_shift;
  assign rd = acc[bus.i_sel];
  assign is_shift = (bus.i_op == OP_SHL || bus.i_op == OP_SHR) && bus.i_shamt != '0;
  accum_alu #(.BITS(BITS)) alu (.op(bus.i_op), .a(rd), .b(bus.i_data), .res(alu_res), .carry(alu_c));
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NACC; i++) acc[i] <= '0;
      state <= IDLE;
      tgt <= '0;
      cnt <= '0;
      shl <= 1'b0;
      carry <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && bus.i_valid) begin
        if (is_shift) begin
          state <= SHIFT;
          tgt <= bus.i_sel;
          cnt <= bus.i_shamt > SHW'(BITS) ? SHW'(BITS) : bus.i_shamt;
          shl <= bus.i_op == OP_SHL;
        end else begin
          acc[bus.i_sel] <= alu_res;
          carry <= alu_c;
          done <= 1'b1;
        end
      end else if (state == SHIFT) begin
        acc[tgt] <= shl ? {acc[tgt][BITS-2:0], 1'b0} : {1'b0, acc[tgt][BITS-1:1]};
        carry <= shl ? acc[tgt][BITS-1] : acc[tgt][0];
        cnt <= cnt - SHW'(1);
        if (cnt == SHW'(1)) begin
          state <= IDLE;
          done <= 1'b1;
        end
      end
    end
  end
  assign bus.o_ready = state == IDLE;
  assign bus.o_data = rd;
  assign bus.o_zero = rd == '0;
  assign bus.o_neg = rd[BITS-1];
  assign bus.o_carry = carry;
  assign bus.o_done = done;
endmodule

// File: tb/tb_accum_bank.sv
// tb_accum_bank: directed and randomized checks of accum_bank against an arithmetic reference model
module tb_accum_bank;
  import accum_pkg::*;
  localparam int BITS = 8;
  localparam int NACC = 4;
  localparam int MASK = (1 << BITS) - 1;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int unsigned m_acc [NACC];
  bit m_c;
  accum_if #(.BITS(BITS), .NACC(NACC)) bus ();
  accum_bank #(.BITS(BITS), .NACC(NACC)) dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus.slave));
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: result of one whole operation, plus the number of shift cycles it occupies
  task automatic model(input int op, input int sel, input int d, input int sh, output int n);
    int unsigned a, s;
    a = m_acc[sel];
    n = 0;
    case (op)
      0: begin m_acc[sel] = d; m_c = 0; end
      1: begin s = a + d; m_acc[sel] = s & MASK; m_c = s > MASK; end
      2: begin m_c = d > a; m_acc[sel] = (a - d) & MASK; end
      3: begin m_acc[sel] = a & d; m_c = 0; end
      4: begin m_acc[sel] = a | d; m_c = 0; end
      5: begin m_acc[sel] = a ^ d; m_c = 0; end
      default: begin
        n = sh > BITS ? BITS : sh;
        if (n == 0) m_c = 0;
        else if (op == 6) begin
          m_c = ((a >> (BITS - n)) & 1) != 0;
          m_acc[sel] = (a << n) & MASK;
        end else begin
          m_c = ((a >> (n - 1)) & 1) != 0;
          m_acc[sel] = a >> n;
        end
      end
    endcase
  endtask

  task automatic check_all();
    for (int j = 0; j < NACC; j++) begin
      bus.i_sel = j[1:0];
      #1;
      chk($sformatf("data%0d", j), bus.o_data, m_acc[j]);
      chk($sformatf("zero%0d", j), bus.o_zero, m_acc[j] == 0);
      chk($sformatf("neg%0d", j), bus.o_neg, (m_acc[j] >> (BITS - 1)) & 1);
    end
  endtask

  task automatic do_op(input op_t op, input int sel, input int d, input int sh, input bit noise);
    int n;
    bus.i_valid = 1'b1;
    bus.i_op = op;
    bus.i_sel = sel[1:0];
    bus.i_data = d[BITS-1:0];
    bus.i_shamt = sh[3:0];
    model(int'(op), sel, d, sh, n);
    @(posedge i_clk);
    #1;
    if (noise) begin
      bus.i_op = OP_LOAD;
      bus.i_data = 8'h55;
    end
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin
        @(posedge i_clk);
        #1;
      end
      chk($sformatf("done op%0d k%0d", op, k), bus.o_done, k == n);
      chk($sformatf("ready op%0d k%0d", op, k), bus.o_ready, k == n);
      bus.i_valid = noise && k < n;
    end
    chk($sformatf("result op%0d", op), bus.o_data, m_acc[sel]);
    chk($sformatf("carry op%0d", op), bus.o_carry, m_c);
    @(posedge i_clk);
    #1;
    chk("done pulse end", bus.o_done, 0);
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_op = OP_LOAD;
    bus.i_sel = '0;
    bus.i_data = '0;
    bus.i_shamt = '0;
    for (int j = 0; j < NACC; j++) m_acc[j] = 0;
    m_c = 0;
    bus.i_valid = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    bus.i_valid = 1'b0;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("rst ready", bus.o_ready, 1);
    chk("rst zero", bus.o_zero, 1);
    chk("rst neg", bus.o_neg, 0);
    chk("rst carry", bus.o_carry, 0);
    chk("rst done", bus.o_done, 0);
    check_all();
    do_op(OP_LOAD, 1, 'hF0, 0, 0);
    do_op(OP_ADD, 1, 'h20, 0, 0);
    chk("add carry", bus.o_carry, 1);
    check_all();
    do_op(OP_LOAD, 2, 'h05, 0, 0);
    do_op(OP_SUB, 2, 'h06, 0, 0);
    chk("sub neg", bus.o_neg, 1);
    do_op(OP_SUB, 2, 'hFF, 0, 0);
    chk("sub zero", bus.o_zero, 1);
    check_all();
    do_op(OP_LOAD, 3, 'h81, 0, 0);
    do_op(OP_SHL, 3, 0, 3, 1);
    chk("shl value", bus.o_data, 'h08);
    check_all();
    do_op(OP_LOAD, 3, 'h81, 0, 0);
    do_op(OP_SHR, 3, 0, 1, 0);
    chk("shr carry", bus.o_carry, 1);
    do_op(OP_LOAD, 0, 'hAA, 0, 0);
    do_op(OP_SHR, 0, 0, 12, 0);
    chk("sat zero", bus.o_zero, 1);
    do_op(OP_LOAD, 0, 'hAA, 0, 0);
    do_op(OP_ADD, 0, 'hF0, 0, 0);
    do_op(OP_SHL, 0, 0, 0, 0);
    chk("shamt0 hold", bus.o_data, 'h9A);
    check_all();
    do_op(OP_LOAD, 3, 'hFF, 0, 0);
    bus.i_valid = 1'b1;
    bus.i_op = OP_SHL;
    bus.i_sel = 2'd3;
    bus.i_shamt = 4'd5;
    @(posedge i_clk);
    #1;
    bus.i_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    for (int j = 0; j < NACC; j++) m_acc[j] = 0;
    m_c = 0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("abort done k%0d", k), bus.o_done, 0);
      chk($sformatf("abort ready k%0d", k), bus.o_ready, 1);
      @(posedge i_clk);
      #1;
    end
    chk("abort carry", bus.o_carry, 0);
    check_all();
    for (int t = 0; t < 60; t++) begin
      do_op(op_t'($urandom_range(0, 7)), int'($urandom_range(0, NACC - 1)),
            int'($urandom_range(0, MASK)), int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
      if (t % 6 == 5) check_all();
    end
    check_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
